// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snake_pkg
//  Description : Shared types and constants for the snake game blocks:
//                session state encoding, tick counter width, default
//                tick periods and the level-to-period helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    // Width of the movement tick counter and period register
    localparam int CNT_W = 30;

    // Default level-0 tick periods in 100 MHz clocks
    localparam int unsigned DEF_EASY_BASE = 2_500_000;
    localparam int unsigned DEF_HARD_BASE = 1_000_000;

    // Session state encoding, also presented on the state output
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Base period shortened by dec, floored at min_p; an oversized
    // decrement (which would wrap) also lands on the floor.
    function automatic logic [31:0] speed_period(
        input logic [31:0] base,
        input logic [31:0] dec,
        input logic [31:0] min_p
    );
        logic [31:0] v;
        if (dec >= base) begin
            v = min_p;
        end else if ((base - dec) < min_p) begin
            v = min_p;
        end else begin
            v = base - dec;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_speed_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : snake_speed_ctrl_if
//  Description : Control bus between the button/collision/update logic
//                (master) and the snake game-rate controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface snake_speed_ctrl_if;

    logic       sw;
    logic       start;
    logic       pause;
    logic       food_eaten;
    logic       game_over;
    logic       tick;
    logic [3:0] level;
    logic [1:0] state;

    modport master (
        output sw, start, pause, food_eaten, game_over,
        input  tick, level, state
    );

    modport slave (
        input  sw, start, pause, food_eaten, game_over,
        output tick, level, state
    );

endinterface
`default_nettype wire

// File: rtl/snake_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : snake_tick_gen
//  Description : Movement tick generator. Counts enabled cycles up to the
//                current period, emits a registered one-cycle tick at the
//                wrap and only then adopts the next period, so a period is
//                never cut short mid-count.
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_tick_gen
    import snake_pkg::*;
#(
    parameter int unsigned RESET_PERIOD = DEF_EASY_BASE
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             en,
    input  wire logic             clr,
    input  wire logic             ld,
    input  wire logic [CNT_W-1:0] period_next,
    output logic                  tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic             r_tick;

    // Counter, active period and tick strobe; clear wins over enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_period <= CNT_W'(RESET_PERIOD);
            r_tick   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (clr) begin
                r_cnt <= '0;
                if (ld) begin
                    r_period <= period_next;
                end
            end else if (en) begin
                if (r_cnt == (r_period - CNT_W'(1))) begin
                    r_tick   <= 1'b1;
                    r_cnt    <= '0;
                    r_period <= period_next;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/snake_speed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : snake_speed_ctrl
//  Description : Snake game-rate controller. Sequences the session
//                (IDLE/RUN/PAUSE/OVER), owns the movement tick and raises
//                the speed level as food is eaten.
//                Build option: define SNAKE_SPEEDUP_EN to build the food
//                counter and level logic; otherwise level stays 0 and the
//                tick period is always the latched mode's base.
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_speed_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned EASY_BASE       = DEF_EASY_BASE,
    parameter int unsigned HARD_BASE       = DEF_HARD_BASE,
    parameter int unsigned STEP            = 100_000,
    parameter int unsigned MIN_PERIOD      = 250_000,
    parameter int unsigned FOODS_PER_LEVEL = 4,
    parameter int unsigned MAX_LEVEL       = 15
) (
    input  wire logic            clk,
    input  wire logic            reset,
    snake_speed_ctrl_if.slave    bus
);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_start_go;
    logic             w_food_en;
    logic             w_run;
    logic             w_clr;
    logic             r_mode_easy;
    logic [3:0]       w_level;
    logic [31:0]      w_base_run;
    logic [31:0]      w_base_start;
    logic [CNT_W-1:0] w_period_next;
    logic             w_tick;

    // Session state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-cycle control; game_over beats pause beats food
    always_comb begin
        w_state_next = r_state;
        w_start_go   = 1'b0;
        w_food_en    = 1'b0;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    w_state_next = ST_RUN;
                    w_start_go   = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.game_over) begin
                    w_state_next = ST_OVER;
                end else if (bus.pause) begin
                    w_state_next = ST_PAUSE;
                end else if (bus.food_eaten) begin
                    w_food_en = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (bus.game_over) begin
                    w_state_next = ST_OVER;
                end else if (bus.pause) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Mode is latched only when a session starts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode_easy <= 1'b1;
        end else if (w_start_go) begin
            r_mode_easy <= bus.sw;
        end
    end

    assign w_base_run   = r_mode_easy ? 32'(EASY_BASE) : 32'(HARD_BASE);
    assign w_base_start = bus.sw      ? 32'(EASY_BASE) : 32'(HARD_BASE);

`ifdef SNAKE_SPEEDUP_EN
    localparam int FOOD_W = (FOODS_PER_LEVEL > 1) ? $clog2(FOODS_PER_LEVEL) : 1;

    logic [FOOD_W-1:0] r_food;
    logic [3:0]        r_level;
    logic [31:0]       w_period_run;

    // Food count wraps every FOODS_PER_LEVEL pulses and bumps the level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_food  <= '0;
            r_level <= 4'd0;
        end else if (w_start_go) begin
            r_food  <= '0;
            r_level <= 4'd0;
        end else if (w_food_en) begin
            if (r_food == FOOD_W'(FOODS_PER_LEVEL - 1)) begin
                r_food <= '0;
                if (r_level != 4'(MAX_LEVEL)) begin
                    r_level <= r_level + 4'd1;
                end
            end else begin
                r_food <= r_food + FOOD_W'(1);
            end
        end
    end

    assign w_level      = r_level;
    assign w_period_run = speed_period(w_base_run, 32'(r_level) * 32'(STEP), 32'(MIN_PERIOD));
`else
    localparam int unsigned c_unused_params = STEP + MIN_PERIOD + FOODS_PER_LEVEL + MAX_LEVEL;

    logic        w_unused_food;
    logic [31:0] w_period_run;

    assign w_unused_food = bus.food_eaten ^ w_food_en;
    assign w_level       = 4'd0;
    assign w_period_run  = w_base_run;
`endif

    // A session starts at level 0 of the freshly sampled mode
    assign w_period_next = w_start_go ? CNT_W'(w_base_start) : CNT_W'(w_period_run);

    assign w_run = (r_state == ST_RUN);
    assign w_clr = (r_state == ST_IDLE) || (r_state == ST_OVER);

    snake_tick_gen #(
        .RESET_PERIOD (EASY_BASE)
    ) u_tick_gen (
        .clk         (clk),
        .reset       (reset),
        .en          (w_run),
        .clr         (w_clr),
        .ld          (w_start_go),
        .period_next (w_period_next),
        .tick        (w_tick)
    );

    assign bus.tick  = w_tick;
    assign bus.level = w_level;
    assign bus.state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_snake_speed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snake_speed_ctrl
//  Description : Self-checking bench for snake_speed_ctrl with scaled
//                parameters; directed session scenarios followed by
//                randomized pulses, all checked against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_speed_ctrl;

    localparam int EASY = 20;
    localparam int HARD = 10;
    localparam int STP  = 4;
    localparam int MINP = 3;
    localparam int FPL  = 2;
    localparam int MAXL = 3;

`ifdef SNAKE_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;

    snake_speed_ctrl_if bus ();

    snake_speed_ctrl #(
        .EASY_BASE       (EASY),
        .HARD_BASE       (HARD),
        .STEP            (STP),
        .MIN_PERIOD      (MINP),
        .FOODS_PER_LEVEL (FPL),
        .MAX_LEVEL       (MAXL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_seen = 0;

    // Behavioural model: session state, level, food tally, RUN cycles
    // elapsed in the current period, and the period being timed.
    int m_state;
    int m_level;
    int m_foods;
    int m_elapsed;
    int m_period;
    bit m_easy;
    bit m_tick;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int period_for(input bit easy, input int lvl);
        int p;
        p = (easy ? EASY : HARD) - lvl * STP;
        if (p < MINP) p = MINP;
        return p;
    endfunction

    task automatic model_reset();
        m_state = 0; m_level = 0; m_foods = 0; m_elapsed = 0;
        m_period = EASY; m_easy = 1'b1; m_tick = 1'b0;
    endtask

    // What one clock edge does, given the inputs present before it
    task automatic model_edge(input bit s_sw, input bit s_start, input bit s_pause,
                              input bit s_food, input bit s_go);
        m_tick = 1'b0;
        if (m_state == 1) begin
            m_elapsed++;
            if (m_elapsed == m_period) begin
                m_tick    = 1'b1;
                m_elapsed = 0;
                m_period  = period_for(m_easy, m_level);
            end
        end
        case (m_state)
            0, 3: if (s_start) begin
                m_state = 1; m_level = 0; m_foods = 0; m_elapsed = 0;
                m_easy = s_sw; m_period = period_for(s_sw, 0);
            end
            1: begin
                if (s_go) m_state = 3;
                else if (s_pause) m_state = 2;
                else if (s_food && SPEEDUP) begin
                    m_foods++;
                    if (m_foods == FPL) begin
                        m_foods = 0;
                        if (m_level < MAXL) m_level++;
                    end
                end
            end
            default: begin
                if (s_go) m_state = 3;
                else if (s_pause) m_state = 1;
            end
        endcase
    endtask

    // One cycle: check last edge's outputs, drive new inputs, predict the edge
    task automatic step(input bit s_sw, input bit s_start, input bit s_pause,
                        input bit s_food, input bit s_go);
        @(negedge clk);
        check("tick", 32'(bus.tick), 32'(m_tick));
        check("state", 32'(bus.state), 32'(m_state));
        check("level", 32'(bus.level), 32'(m_level));
        if (bus.tick) tick_seen++;
        bus.sw = s_sw; bus.start = s_start; bus.pause = s_pause;
        bus.food_eaten = s_food; bus.game_over = s_go;
        model_edge(s_sw, s_start, s_pause, s_food, s_go);
    endtask

    task automatic idle(input int n, input bit s_sw);
        for (int i = 0; i < n; i++) step(s_sw, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset in mid-cycle; outputs must drop at once
    task automatic do_reset();
        @(negedge clk);
        bus.sw = ~bus.sw; bus.start = 1'b0; bus.pause = 1'b0;
        bus.food_eaten = 1'b0; bus.game_over = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_tick", 32'(bus.tick), 32'd0);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_level", 32'(bus.level), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    int lvl_before;

    initial begin
        bus.sw = 1'b1; bus.start = 1'b0; bus.pause = 1'b0;
        bus.food_eaten = 1'b0; bus.game_over = 1'b0;
        model_reset();
        do_reset();

        // Easy session: ticks 20, 40, 60 cycles after entry
        tick_seen = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(65, 1'b1);
        check("s1_ticks", 32'(tick_seen), 32'd3);

        // Hard session with a level-up mid-period
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(30, 1'b1);

        // Eight more foods: level saturates, period floors at MINP
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle(15, 1'b0);
        check("s3_level", 32'(bus.level), SPEEDUP ? 32'(MAXL) : 32'd0);

        // Pause partway through a 10-cycle period, then resume
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(10, 1'b0);
        idle(6, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(50, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(12, 1'b0);

        // Food and game_over together: food discarded, session over
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        lvl_before = m_level;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s5_state", 32'(bus.state), 32'd3);
        check("s5_level", 32'(bus.level), 32'(lvl_before));
        idle(30, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(25, 1'b1);

        // Reset in the middle of a run, no tick before a new start
        do_reset();
        tick_seen = 0;
        idle(40, 1'b0);
        check("s6_no_tick", 32'(tick_seen), 32'd0);

        // Randomized pulses with occasional asynchronous reset
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1499) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)),
                     $urandom_range(0, 11) == 0,
                     $urandom_range(0, 39) == 0,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 399) == 0);
            end
        end
        idle(2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snake_speed_ctrl.md
# snake_speed_ctrl

Game-rate controller for the snake game. Owns the movement tick, so the body-update logic advances exactly one step per `tick` strobe. Also sequences the game session (idle, run, pause, over) and speeds the game up as food is eaten. Sits between the debounced button/switch inputs and the snake-update/VGA logic, running on the 100 MHz system clock.

## Interface
Parameters:
- EASY_BASE, 2_500_000: tick period in clocks at level 0, easy mode
- HARD_BASE, 1_000_000: tick period in clocks at level 0, hard mode
- STEP, 100_000: period reduction per level
- MIN_PERIOD, 250_000: floor on the period; must be ≥ 2
- FOODS_PER_LEVEL, 4: food events needed per level-up; must be ≥ 1
- MAX_LEVEL, 15: level saturation value; must be ≤ 15

Ports:
- clk  in  1  system clock; the block's only clock
- reset  in  1  asynchronous, active-high reset
- sw  in  1  mode select: 1 = easy (caterpillar), 0 = hard (desert snake)
- start  in  1  single-cycle pulse from the debouncer
- pause  in  1  single-cycle pulse; toggles pause
- food_eaten  in  1  single-cycle pulse from the snake-update logic
- game_over  in  1  single-cycle pulse from collision logic
- tick  out  1  one-cycle movement strobe
- level  out  4  current speed level
- state  out  2  session state: IDLE=0, RUN=1, PAUSE=2, OVER=3

## Operation
- Reset values: state=IDLE, tick=0, level=0, food count=0, counter=0, period register=EASY_BASE, latched mode=easy.

FSM, evaluated each clock:
- **IDLE or OVER**, `start` asserted: go to RUN. Clear level, food count and counter. Latch `sw` as the mode. Load the period register with the level-0 base for the latched mode. `pause`, `food_eaten` and `game_over` are ignored in these states.
- **RUN**, priority order:
  - `game_over` → OVER.
  - else `pause` → PAUSE.
  - else count `food_eaten`.
  - `start` is ignored.
- **PAUSE**, priority order:
  - `game_over` → OVER.
  - else `pause` → RUN.
  - `food_eaten` and `start` are ignored.
- `sw` is sampled only on the start transition. Mid-game changes have no effect.

Counter and tick:
- 30-bit counter, advancing only in RUN.
- When counter == period_q−1: assert `tick` for that cycle, set counter to 0, and set period_q to period_next.
- Otherwise the counter increments by 1.
- PAUSE holds the counter value, so RUN resumes the partial period.
- OVER clears the counter. `tick` is 0 in every state except RUN.

Speed:
- The food count runs 0..FOODS_PER_LEVEL−1.
- A `food_eaten` pulse when the count equals FOODS_PER_LEVEL−1 wraps the count to 0 and increments `level`, saturating at MAX_LEVEL. At saturation the food count still wraps.
- period_next = base − level·STEP.
  - Computed in 32-bit unsigned arithmetic.
  - If level·STEP ≥ base or the result < MIN_PERIOD, use MIN_PERIOD.
- A level change takes effect at the next tick boundary only; the current period is never shortened mid-count.

## Timing
- The first tick comes period_q cycles after the clock edge that enters RUN.
- Ticks are then spaced exactly period_q cycles apart, counting RUN cycles only.
- `level` and `state` are registered. They update on the clock edge after the causing pulse.
- Async `reset` mid-operation returns every output to its reset value immediately. There is no tick on the release edge.
- Simultaneous `food_eaten` and `game_over` in RUN: the state goes to OVER, the food is not counted, and the level is unchanged.
- If `tick` and `game_over` fall on the same cycle, `tick` is still asserted that cycle.

## Configuration
- `SNAKE_SPEEDUP_EN` defined: level-up behaviour as described above.
- Undefined: the food counter and level logic are not built. `level` is tied to 0 and the period is always the mode base. `food_eaten` is unused.

## Structure
- `snake_pkg` holds:
  - state encoding (IDLE/RUN/PAUSE/OVER)
  - the 30-bit counter width
  - default EASY_BASE / HARD_BASE constants, shared with other game blocks
- One sub-module, `snake_tick_gen`. It contains the counter, period_q, and the load-at-wrap logic, with an enable input, a clear input and a period_next input.
- The FSM, food counter and period computation sit in the top module.

## Test plan
Use scaled parameters: EASY_BASE=20, HARD_BASE=10, STEP=4, MIN_PERIOD=3, FOODS_PER_LEVEL=2, MAX_LEVEL=3.
1. Reset, then `start` with sw=1 → state=1; ticks at 20, 40, 60 cycles after entry; level=0.
2. Hard mode, then 2 `food_eaten` pulses mid-period → level=1 one cycle later; current gap stays 10; following gaps are 6.
3. 8 food pulses in hard mode → level saturates at 3; period 10−12 underflows → gaps are MIN_PERIOD=3.
4. `pause` at counter 7 (period 10), hold 50 cycles, `pause` again → no ticks while paused; next tick 3 RUN cycles after resume.
5. `food_eaten` and `game_over` in the same cycle → state=3, level unchanged, no further ticks; then `start` → state=1, level=0.
6. Assert `reset` mid-RUN with sw toggled → state=0, tick=0, level=0; no tick until a new `start`.
